// File: rtl/rv_mem_pkg.sv
// Shared types and address helpers for the rv_mem_responder memory slice.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Word index of a byte address; callers cast the result to their index width.
  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rv_mem_responder_if.sv
// Core fetch/data ports and host loader ports of the memory responder.
interface rv_mem_responder_if;
  logic        core_halted;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        host_go;

  modport master (
    output core_halted, imem_addr, dmem_we, dmem_addr, dmem_wdata,
           host_valid, host_we, host_addr, host_wdata, host_go,
    input  imem_rdata, dmem_rdata, host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  core_halted, imem_addr, dmem_we, dmem_addr, dmem_wdata,
           host_valid, host_we, host_addr, host_wdata, host_go,
    output imem_rdata, dmem_rdata, host_ready, host_rvalid, host_rdata
  );
endinterface

// File: rtl/rv_mem_ram.sv
// Unified word RAM: one synchronous write port, two asynchronous read ports.
module rv_mem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   rdata_b
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset; the responder's clear sequence zeroes it word by word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/rv_mem_responder.sv
// Memory responder: clear / host preload / core run / host dump sequencing.
// Optional RV_MEM_ACCESS_COUNT_EN adds saturating load/store/fetch counters.
module rv_mem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               core_rstn,
  rv_mem_responder_if.slave  bus,
  output logic [1:0]         state_o,
  output logic               oob_err,
`ifdef RV_MEM_ACCESS_COUNT_EN
  output logic               misalign_err,
  output logic [31:0]        ld_count,
  output logic [31:0]        st_count,
  output logic [31:0]        if_count
`else
  output logic               misalign_err
`endif
);

  state_t        state, state_nx;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] i_idx, d_idx, h_idx, shared_idx, waddr;
  logic          i_ok, d_ok, h_ok;
  logic          host_acc, host_rd_acc, host_wr_acc;
  logic          we;
  logic [31:0]   wdata, rdata_i, rdata_s;
  logic          oob_hit, mis_hit;

  assign i_idx = AW'(word_idx(bus.imem_addr));
  assign d_idx = AW'(word_idx(bus.dmem_addr));
  assign h_idx = AW'(word_idx(bus.host_addr));
  assign i_ok  = in_range(bus.imem_addr, AW);
  assign d_ok  = in_range(bus.dmem_addr, AW);
  assign h_ok  = in_range(bus.host_addr, AW);

  always_comb begin
    bus.host_ready = 1'b0;
    unique case (state)
      S_LOAD:        bus.host_ready = 1'b1;
      S_RUN, S_DONE: bus.host_ready = !bus.host_we;
      default:       bus.host_ready = 1'b0;
    endcase
  end

  assign host_acc    = bus.host_valid & bus.host_ready;
  assign host_rd_acc = host_acc & !bus.host_we;
  assign host_wr_acc = host_acc & bus.host_we;

  // A host read borrows the shared read port for its cycle; the core sees that word on dmem_rdata.
  assign shared_idx     = host_rd_acc ? h_idx : d_idx;
  assign bus.imem_rdata = i_ok ? rdata_i : 32'h0;
  assign bus.dmem_rdata = d_ok ? rdata_s : 32'h0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    we    = 1'b0;
    waddr = d_idx;
    wdata = bus.dmem_wdata;
    unique case (state)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = 32'h0;
      end
      S_LOAD: begin
        we    = host_wr_acc & h_ok;
        waddr = h_idx;
        wdata = bus.host_wdata;
      end
      S_RUN:   we = bus.dmem_we & d_ok;
      default: we = 1'b0;
    endcase
  end

  rv_mem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (i_idx),
    .rdata_a (rdata_i),
    .raddr_b (shared_idx),
    .rdata_b (rdata_s)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_CLEAR: if (clr_cnt == AW'(DEPTH_WORDS - 1)) state_nx = S_LOAD;
      S_LOAD:  if (bus.host_go)     state_nx = S_RUN;
      S_RUN:   if (bus.core_halted) state_nx = S_DONE;
      default: state_nx = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nx;
  end

  // Core addresses are only meaningful while the core runs; host ones only when accepted.
  assign oob_hit = ((state == S_RUN) & (!i_ok | !d_ok)) | (host_acc & !h_ok);
  assign mis_hit = ((state == S_RUN) & (misaligned(bus.imem_addr) | misaligned(bus.dmem_addr)))
                 | (host_acc & misaligned(bus.host_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt         <= '0;
      core_rstn       <= 1'b0;
      bus.host_rvalid <= 1'b0;
      bus.host_rdata  <= 32'h0;
      oob_err         <= 1'b0;
      misalign_err    <= 1'b0;
    end else begin
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      core_rstn       <= (state_nx == S_RUN) || (state_nx == S_DONE);
      bus.host_rvalid <= host_rd_acc;
      if (host_rd_acc) bus.host_rdata <= h_ok ? rdata_s : 32'h0;
      oob_err         <= oob_err | oob_hit;
      misalign_err    <= misalign_err | mis_hit;
    end
  end

  assign state_o = state;

`ifdef RV_MEM_ACCESS_COUNT_EN
  logic [31:0] prev_dmem_addr, prev_imem_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_count       <= 32'h0;
      st_count       <= 32'h0;
      if_count       <= 32'h0;
      prev_dmem_addr <= 32'h0;
      prev_imem_addr <= 32'h0;
    end else begin
      prev_dmem_addr <= bus.dmem_addr;
      prev_imem_addr <= bus.imem_addr;
      if (state == S_RUN) begin
        if (core_rstn && !bus.dmem_we && bus.dmem_addr != prev_dmem_addr && ld_count != 32'hFFFF_FFFF)
          ld_count <= ld_count + 32'd1;
        if (bus.dmem_we && st_count != 32'hFFFF_FFFF)
          st_count <= st_count + 32'd1;
        if (bus.imem_addr != prev_imem_addr && if_count != 32'hFFFF_FFFF)
          if_count <= if_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rv_mem_responder.sv
// Directed bench for rv_mem_responder: clear timing, preload, run, halt, dump, reset restart.
module tb_rv_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_rstn;
  logic [1:0] state_o;
  logic       oob_err;
  logic       misalign_err;
`ifdef RV_MEM_ACCESS_COUNT_EN
  logic [31:0] ld_count, st_count, if_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  rv_mem_responder_if bus ();

  rv_mem_responder #(.DEPTH_WORDS(1024), .AW(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_rstn    (core_rstn),
    .bus          (bus),
    .state_o      (state_o),
    .oob_err      (oob_err),
`ifdef RV_MEM_ACCESS_COUNT_EN
    .misalign_err (misalign_err),
    .ld_count     (ld_count),
    .st_count     (st_count),
    .if_count     (if_count)
`else
    .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_load(input int budget, output int cycles);
    cycles = 0;
    while (state_o !== 2'd1 && cycles < budget) begin
      tick;
      cycles = cycles + 1;
    end
  endtask

  task automatic host_read(input logic [31:0] addr);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = addr;
    tick;
    bus.host_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.core_halted = 1'b0;
    bus.imem_addr   = 32'h10;
    bus.dmem_we     = 1'b0;
    bus.dmem_addr   = 32'h0;
    bus.dmem_wdata  = 32'h0;
    bus.host_valid  = 1'b0;
    bus.host_we     = 1'b0;
    bus.host_addr   = 32'h0;
    bus.host_wdata  = 32'h0;
    bus.host_go     = 1'b0;
    tick;
    tick;

    check("rst_state",     32'(state_o), 32'd0);
    check("rst_core_rstn", 32'(core_rstn), 32'd0);
    check("rst_ready",     32'(bus.host_ready), 32'd0);
    check("rst_rvalid",    32'(bus.host_rvalid), 32'd0);
    check("rst_rdata",     bus.host_rdata, 32'h0);
    check("rst_oob",       32'(oob_err), 32'd0);
    check("rst_mis",       32'(misalign_err), 32'd0);
    rst = 1'b0;

    wait_load(2000, cyc);
    check("clear_cycles", 32'(cyc), 32'd1024);

    // Last word read in S_LOAD: ready combinational, data one edge after accept.
    bus.host_valid = 1'b1;
    bus.host_addr  = 32'h0FFC;
    #1;
    check("load_ready_rd", 32'(bus.host_ready), 32'd1);
    tick;
    bus.host_valid = 1'b0;
    check("ffc_rvalid", 32'(bus.host_rvalid), 32'd1);
    check("ffc_rdata",  bus.host_rdata, 32'h0);
    tick;
    check("rvalid_drop", 32'(bus.host_rvalid), 32'd0);

    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 32'h10;
    bus.host_wdata = 32'h3F80_0000;
    tick;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    host_read(32'h10);
    check("load_readback", bus.host_rdata, 32'h3F80_0000);
    check("load_core_rstn", 32'(core_rstn), 32'd0);

    bus.host_go = 1'b1;
    tick;
    bus.host_go = 1'b0;
    check("go_core_rstn", 32'(core_rstn), 32'd1);
    check("go_state",     32'(state_o), 32'd2);
    #1;
    check("fetch_10", bus.imem_rdata, 32'h3F80_0000);

    // Core store plus refused host write in the same cycle.
    bus.dmem_we    = 1'b1;
    bus.dmem_addr  = 32'h20;
    bus.dmem_wdata = 32'h4040_0000;
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 32'h30;
    bus.host_wdata = 32'hDEAD_BEEF;
    #1;
    check("run_ready_wr", 32'(bus.host_ready), 32'd0);
    check("pre_edge_old", bus.dmem_rdata, 32'h0);
    tick;
    bus.dmem_we    = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    #1;
    check("raw_20", bus.dmem_rdata, 32'h4040_0000);
    bus.dmem_addr = 32'h30;
    #1;
    check("host_wr_dropped", bus.dmem_rdata, 32'h0);
    check("oob_clean", 32'(oob_err), 32'd0);
    check("mis_clean", 32'(misalign_err), 32'd0);

    bus.dmem_we    = 1'b1;
    bus.dmem_addr  = 32'h1000;
    bus.dmem_wdata = 32'h1234_5678;
    tick;
    bus.dmem_we   = 1'b0;
    bus.dmem_addr = 32'h0;
    #1;
    check("oob_set",      32'(oob_err), 32'd1);
    check("oob_no_alias", bus.dmem_rdata, 32'h0);
    check("mis_still_0",  32'(misalign_err), 32'd0);
    bus.imem_addr = 32'h1004;
    #1;
    check("fetch_oob", bus.imem_rdata, 32'h0);
    bus.imem_addr = 32'h10;

    bus.dmem_addr = 32'h22;
    #1;
    check("load_22", bus.dmem_rdata, 32'h4040_0000);
    tick;
    check("mis_set", 32'(misalign_err), 32'd1);
    bus.dmem_addr = 32'h20;

    host_read(32'h20);
    check("run_host_rd", bus.host_rdata, 32'h4040_0000);

    bus.core_halted = 1'b1;
    tick;
    bus.core_halted = 1'b0;
    check("halt_state",     32'(state_o), 32'd3);
    check("halt_core_rstn", 32'(core_rstn), 32'd1);
    host_read(32'h10);
    check("dump_10",     bus.host_rdata, 32'h3F80_0000);
    check("dump_rvalid", 32'(bus.host_rvalid), 32'd1);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    #1;
    check("done_ready_wr", 32'(bus.host_ready), 32'd0);
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;

    // Reset from S_DONE restarts the clear and wipes memory.
    rst = 1'b1;
    tick;
    check("rst2_state", 32'(state_o), 32'd0);
    check("rst2_rdata", bus.host_rdata, 32'h0);
    check("rst2_oob",   32'(oob_err), 32'd0);
    check("rst2_mis",   32'(misalign_err), 32'd0);
    rst = 1'b0;
    wait_load(2000, cyc);
    check("clear2_cycles", 32'(cyc), 32'd1024);
    host_read(32'h10);
    check("cleared_10", bus.host_rdata, 32'h0);

    bus.host_go = 1'b1;
    tick;
    bus.host_go   = 1'b0;
    bus.dmem_addr = 32'h22;
    tick;
    check("run2_mis", 32'(misalign_err), 32'd1);
    rst = 1'b1;
    tick;
    check("rst3_core_rstn", 32'(core_rstn), 32'd0);
    check("rst3_state",     32'(state_o), 32'd0);
    check("rst3_mis",       32'(misalign_err), 32'd0);
    check("rst3_rvalid",    32'(bus.host_rvalid), 32'd0);
    rst = 1'b0;
    bus.dmem_addr = 32'h0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
